// File: rtl/coherence_bus_if.sv
// coherence_bus_if: signal bundle between two cores' caches, the single-port RAM and coherence_bus_ctrl
// slave  : controller side (takes cache requests and RAM replies, drives waits, loads, snoops, RAM strobes)
// master : cache/RAM side (drives requests and RAM replies, observes controller outputs)
interface coherence_bus_if;
  logic [1:0]       iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [1:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: two-core bus arbiter serialising ifetch, write-back and coherent dcache traffic onto one RAM
// Ports: CLK (rising edge), nRST (synchronous, active-low), bus (coherence_bus_if.slave: cache requests,
//   wait/load returns, snoop outputs ccwait/ccinv/ccsnoopaddr, RAM strobes/address/data, ramload/ramstate).
// Config: RR_ARB_EN defined -> round-robin tie-break inside a request class; undefined -> core 0 wins ties.
module coherence_bus_ctrl (
  input logic            CLK,
  input logic            nRST,
  coherence_bus_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IFETCH, WB, SNOOP, C2C, MEMRD} state_t;
  state_t     state_q;
  logic       g_q, r, s, acc, cc_act, win, pref;
  logic [1:0] wb_req, cls_req;
`ifdef RR_ARB_EN
  logic rr_q;
  assign pref = rr_q;
`else
  assign pref = 1'b0;
`endif
  // g_q is the granted core; for coherent transactions it is the requester and the other core is snooped
  assign r = g_q;
  assign s = ~g_q;
  assign acc = bus.ramstate == 2'd2;
  assign wb_req = bus.dWEN & ~bus.cctrans;
  // highest non-empty class is arbitrated; within it the preferred core wins only on a tie
  assign cls_req = |wb_req ? wb_req : |bus.cctrans ? bus.cctrans : bus.iREN;
  assign win = &cls_req ? pref : cls_req[1];
  assign cc_act = state_q inside {SNOOP, C2C, MEMRD};
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      g_q <= 1'b0;
`ifdef RR_ARB_EN
      rr_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (|cls_req) begin
          state_q <= |wb_req ? WB : |bus.cctrans ? SNOOP : IFETCH;
          g_q <= win;
`ifdef RR_ARB_EN
          if (&cls_req) rr_q <= ~win;
`endif
        end
        IFETCH: if (!bus.iREN[g_q] || acc) state_q <= IDLE;
        WB: if (!bus.dWEN[g_q]) state_q <= IDLE;
        SNOOP, C2C: state_q <= !bus.cctrans[r] ? IDLE : bus.dWEN[s] ? C2C : bus.dREN[r] ? MEMRD : IDLE;
        MEMRD: if (!bus.cctrans[r]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  always_comb begin
    bus.ramREN = state_q == IFETCH || state_q == MEMRD;
    bus.ramWEN = state_q == WB || state_q == C2C;
    bus.ramaddr = state_q == IFETCH ? bus.iaddr[g_q] : state_q == C2C ? bus.daddr[s] : bus.daddr[g_q];
    bus.ramstore = state_q == C2C ? bus.dstore[s] : bus.dstore[g_q];
    bus.iload = {2{bus.ramload}};
    // a modified block is forwarded straight from the snooped cache while it is written back
    bus.dload = {2{state_q == C2C ? bus.dstore[s] : bus.ramload}};
    bus.iwait = 2'b11;
    bus.dwait = 2'b11;
    bus.ccwait = 2'b00;
    bus.ccinv = 2'b00;
    bus.ccsnoopaddr = '0;
    if (state_q == IFETCH && acc) bus.iwait[g_q] = 1'b0;
    if ((state_q == WB || state_q == MEMRD) && acc) bus.dwait[g_q] = 1'b0;
    if (state_q == C2C && acc) bus.dwait = 2'b00;
    // upgrade with no data movement completes in the snoop cycle itself
    if (state_q == SNOOP && bus.cctrans[r] && !bus.dWEN[s] && !bus.dREN[r]) bus.dwait[r] = 1'b0;
    bus.ccwait[s] = cc_act;
    bus.ccinv[s] = cc_act && bus.ccwrite[r];
    if (cc_act) bus.ccsnoopaddr[s] = bus.daddr[r];
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: scoreboard bench for coherence_bus_ctrl with a fixed-latency RAM model
module tb_coherence_bus_ctrl;
  typedef struct packed { logic c; logic [31:0] a; logic [31:0] v; } ent_t;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       err_inj = 1'b0;
  logic [1:0] cnt = 2'd0;
  logic [1:0] rd_pend = 2'b00;
  logic       strobe, acc_now, first;
  int         n_cmp = 0;
  int         n_err = 0;
  ent_t       exp_f[$], exp_dl[$], exp_wr[$];
  coherence_bus_if bus ();
  coherence_bus_ctrl dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  function automatic ent_t mk(input logic c, input logic [31:0] a, input logic [31:0] v);
    ent_t e;
    e.c = c;
    e.a = a;
    e.v = v;
    return e;
  endfunction
  assign strobe = bus.ramREN | bus.ramWEN;
  assign acc_now = strobe && cnt == 2'd2 && !err_inj;
  assign bus.ramstate = !strobe ? 2'd0 : err_inj ? 2'd3 : acc_now ? 2'd2 : 2'd1;
  assign bus.ramload = ram_word(bus.ramaddr);
  always @(posedge CLK) cnt <= (!strobe || acc_now) ? 2'd0 : (cnt == 2'd2 ? cnt : cnt + 2'd1);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_i(input int c);
    for (int k = 0; k < 40 && bus.iwait[c]; k++) @(negedge CLK);
    chk("iwait_timeout", 32'(bus.iwait[c]), 32'd0);
  endtask
  task automatic wait_d(input int c);
    for (int k = 0; k < 40 && bus.dwait[c]; k++) @(negedge CLK);
    chk("dwait_timeout", 32'(bus.dwait[c]), 32'd0);
  endtask
  task automatic wait_cc(input int c);
    for (int k = 0; k < 40 && !bus.ccwait[c]; k++) @(negedge CLK);
    chk("ccwait_timeout", 32'(bus.ccwait[c]), 32'd1);
  endtask
  always @(negedge CLK) begin : mon
    ent_t e;
    if (nRST) begin
      for (int c = 0; c < 2; c++) begin
        if (!bus.iwait[c]) begin
          chk("fetch_expected", 32'(exp_f.size() != 0), 32'd1);
          if (exp_f.size() != 0) begin
            e = exp_f.pop_front();
            chk("fetch_core", 32'(c), 32'(e.c));
            chk("fetch_data", bus.iload[c], e.v);
          end
        end
        if (!bus.dwait[c] && rd_pend[c]) begin
          chk("load_expected", 32'(exp_dl.size() != 0), 32'd1);
          if (exp_dl.size() != 0) begin
            e = exp_dl.pop_front();
            chk("load_core", 32'(c), 32'(e.c));
            chk("load_data", bus.dload[c], e.v);
          end
        end
      end
      if (bus.ramWEN && bus.ramstate == 2'd2) begin
        chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("write_addr", bus.ramaddr, e.a);
          chk("write_data", bus.ramstore, e.v);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.iREN = 2'b11;
    bus.dREN = 2'b11;
    bus.dWEN = 2'b11;
    bus.cctrans = 2'b11;
    bus.ccwrite = 2'b11;
    bus.iaddr = '0;
    bus.daddr = '0;
    bus.dstore = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_iwait", 32'(bus.iwait), 32'd3);
    chk("rst_dwait", 32'(bus.dwait), 32'd3);
    chk("rst_ccwait", 32'(bus.ccwait), 32'd0);
    chk("rst_ccinv", 32'(bus.ccinv), 32'd0);
    bus.iREN = 2'b00;
    bus.dREN = 2'b00;
    bus.dWEN = 2'b00;
    bus.cctrans = 2'b00;
    bus.ccwrite = 2'b00;
    step();
    nRST = 1'b1;
    step();
    bus.iaddr[0] = 32'h100;
    bus.iREN = 2'b01;
    exp_f.push_back(mk(1'b0, 32'h100, 32'hDEADBEEF));
    @(negedge CLK);
    chk("if_grant_no_strobe", 32'(bus.ramREN), 32'd0);
    @(negedge CLK);
    chk("if_ramREN", 32'(bus.ramREN), 32'd1);
    chk("if_ramaddr", bus.ramaddr, 32'h100);
    chk("if_busy1", 32'(bus.iwait), 32'd3);
    @(negedge CLK);
    chk("if_busy2", 32'(bus.iwait), 32'd3);
    @(negedge CLK);
    chk("if_done", 32'(bus.iwait), 32'd2);
    step();
    bus.iREN = 2'b00;
    @(negedge CLK);
    chk("if_one_cycle", 32'(bus.iwait), 32'd3);
    step();
    bus.iaddr[0] = 32'h500;
    bus.iaddr[1] = 32'h600;
    bus.iREN = 2'b11;
    exp_f.push_back(mk(1'b0, 32'h500, ram_word(32'h500)));
    wait_i(0);
    step();
    bus.iREN = 2'b10;
    exp_f.push_back(mk(1'b1, 32'h600, ram_word(32'h600)));
    wait_i(1);
    step();
    bus.iREN = 2'b00;
    step();
`ifdef RR_ARB_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    bus.iaddr[0] = 32'h700;
    bus.iaddr[1] = 32'h800;
    bus.iREN = 2'b11;
    exp_f.push_back(mk(first, first ? 32'h800 : 32'h700, ram_word(first ? 32'h800 : 32'h700)));
    wait_i(int'(first));
    step();
    bus.iREN[first] = 1'b0;
    exp_f.push_back(mk(~first, first ? 32'h700 : 32'h800, ram_word(first ? 32'h700 : 32'h800)));
    wait_i(int'(~first));
    step();
    bus.iREN = 2'b00;
    step();
    bus.iaddr[1] = 32'h900;
    bus.iREN = 2'b10;
    err_inj = 1'b1;
    exp_f.push_back(mk(1'b1, 32'h900, ram_word(32'h900)));
    repeat (6) @(negedge CLK);
    chk("err_no_completion", 32'(bus.iwait), 32'd3);
    step();
    err_inj = 1'b0;
    wait_i(1);
    step();
    bus.iREN = 2'b00;
    step();
    bus.dWEN = 2'b01;
    bus.daddr[0] = 32'h300;
    bus.dstore[0] = 32'h1111;
    bus.iREN = 2'b10;
    bus.iaddr[1] = 32'h400;
    exp_wr.push_back(mk(1'b0, 32'h300, 32'h1111));
    exp_f.push_back(mk(1'b1, 32'h400, ram_word(32'h400)));
    @(negedge CLK);
    @(negedge CLK);
    chk("prio_wen", 32'(bus.ramWEN), 32'd1);
    chk("prio_ren", 32'(bus.ramREN), 32'd0);
    wait_d(0);
    step();
    bus.dWEN = 2'b00;
    wait_i(1);
    step();
    bus.iREN = 2'b00;
    step();
    bus.cctrans = 2'b10;
    bus.dREN = 2'b10;
    bus.ccwrite = 2'b10;
    bus.daddr[1] = 32'h200;
    rd_pend = 2'b10;
    exp_dl.push_back(mk(1'b1, 32'h200, 32'h0000CAFE));
    exp_wr.push_back(mk(1'b0, 32'h200, 32'h0000CAFE));
    wait_cc(0);
    chk("snp_ccwait", 32'(bus.ccwait), 32'd1);
    chk("snp_ccinv", 32'(bus.ccinv), 32'd1);
    chk("snp_addr", bus.ccsnoopaddr[0], 32'h200);
    chk("snp_no_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    bus.dWEN = 2'b01;
    bus.daddr[0] = 32'h200;
    bus.dstore[0] = 32'h0000CAFE;
    wait_d(1);
    chk("c2c_src_dwait", 32'(bus.dwait[0]), 32'd0);
    chk("c2c_ramWEN", 32'(bus.ramWEN), 32'd1);
    chk("c2c_ramaddr", bus.ramaddr, 32'h200);
    chk("c2c_ccinv", 32'(bus.ccinv), 32'd1);
    step();
    bus.cctrans = 2'b00;
    bus.dREN = 2'b00;
    bus.ccwrite = 2'b00;
    bus.dWEN = 2'b00;
    rd_pend = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    chk("c2c_exit", 32'({bus.ccwait, bus.ccinv}), 32'd0);
    step();
    bus.cctrans = 2'b10;
    bus.dREN = 2'b10;
    bus.ccwrite = 2'b10;
    bus.daddr[1] = 32'h200;
    rd_pend = 2'b10;
    exp_dl.push_back(mk(1'b1, 32'h200, ram_word(32'h200)));
    wait_cc(0);
    @(negedge CLK);
    chk("miss_ramREN", 32'(bus.ramREN), 32'd1);
    chk("miss_ramaddr", bus.ramaddr, 32'h200);
    chk("miss_ccinv", 32'(bus.ccinv), 32'd1);
    chk("miss_snpaddr", bus.ccsnoopaddr[0], 32'h200);
    wait_d(1);
    step();
    bus.cctrans = 2'b00;
    bus.dREN = 2'b00;
    bus.ccwrite = 2'b00;
    rd_pend = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    chk("miss_exit", 32'(bus.ccwait), 32'd0);
    step();
    bus.cctrans = 2'b01;
    bus.ccwrite = 2'b01;
    bus.daddr[0] = 32'hA00;
    wait_cc(1);
    chk("upg_dwait", 32'(bus.dwait), 32'd2);
    chk("upg_ccinv", 32'(bus.ccinv), 32'd2);
    chk("upg_snpaddr", bus.ccsnoopaddr[1], 32'hA00);
    chk("upg_no_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    step();
    bus.cctrans = 2'b00;
    bus.ccwrite = 2'b00;
    @(negedge CLK);
    chk("upg_exit", 32'(bus.ccwait), 32'd0);
    step();
    bus.dWEN = 2'b10;
    bus.daddr[1] = 32'hB00;
    bus.dstore[1] = 32'h11;
    exp_wr.push_back(mk(1'b1, 32'hB00, 32'h11));
    exp_wr.push_back(mk(1'b1, 32'hB01, 32'h22));
    wait_d(1);
    step();
    bus.daddr[1] = 32'hB01;
    bus.dstore[1] = 32'h22;
    wait_d(1);
    step();
    bus.dWEN = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    chk("wb_idle", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    step();
    bus.iaddr[0] = 32'h100;
    bus.iREN = 2'b01;
    @(negedge CLK);
    @(negedge CLK);
    chk("mrst_ren_before", 32'(bus.ramREN), 32'd1);
    nRST = 1'b0;
    @(negedge CLK);
    chk("mrst_ren", 32'(bus.ramREN), 32'd0);
    chk("mrst_iwait", 32'(bus.iwait), 32'd3);
    bus.iREN = 2'b00;
    step();
    nRST = 1'b1;
    step();
    step();
    chk("sb_empty", 32'(exp_f.size() + exp_dl.size() + exp_wr.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
